// File: rtl/lpddr_burst_engine.sv
// Avalon-MM burst master: write and read data flow through show-ahead FIFOs and move in BURST_LEN-beat bursts.
// Optional stall/beat performance counters are enabled by defining LPDDR_BURST_ENGINE_PERF_EN.

module lpddr_burst_engine_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 128
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_push,
    input  logic [W-1:0]            i_data,
    input  logic                    i_pop,
    output logic [W-1:0]            o_head,
    output logic [$clog2(DEPTH):0]  o_used
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wptr;
    logic [AW:0]  r_rptr;
    logic         w_push;
    logic         w_pop;

    // One extra pointer bit keeps full (used == DEPTH) distinct from empty.
    assign o_used = r_wptr - r_rptr;
    assign w_push = i_push & ~o_used[AW];
    assign w_pop  = i_pop & (o_used != '0);
    assign o_head = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end
endmodule

module lpddr_burst_engine #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 32,
    parameter int BURST_LEN    = 64,
    parameter int BURSTCOUNT_W = 7,
    parameter int LEN_W        = 16,
    parameter int FIFO_DEPTH   = 128
) (
    input  logic                    avmm_m_clk,
    input  logic                    avmm_m_rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_W-1:0]       cmd_address,
    input  logic [LEN_W-1:0]        cmd_bursts,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    wr_overflow,
    output logic [ADDR_W-1:0]       avmm_m_address,
    output logic [BURSTCOUNT_W-1:0] avmm_m_burstcount,
    output logic                    avmm_m_write,
    output logic [DATA_W-1:0]       avmm_m_writedata,
    output logic                    avmm_m_read,
    input  logic                    avmm_m_waitrequest,
    input  logic [DATA_W-1:0]       avmm_m_readdata,
    input  logic                    avmm_m_readdatavalid,
`ifdef LPDDR_BURST_ENGINE_PERF_EN
    output logic [31:0]             stall_cnt,
    output logic [31:0]             beat_cnt,
`endif
    output logic [2:0]              o_dbg_state
);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int BEAT_W = $clog2(BURST_LEN);
    localparam logic [ADDR_W-1:0] BSTEP      = ADDR_W'(BURST_LEN * DATA_W / 8);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(BSTEP - ADDR_W'(1));
    localparam logic [AW:0]       CNT_BURST  = (AW + 1)'(BURST_LEN);
    localparam logic [AW:0]       CNT_DEPTH  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR_WAIT  = 3'd1,
        S_WR_BURST = 3'd2,
        S_RD_ISSUE = 3'd3,
        S_RD_DATA  = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [LEN_W-1:0]    r_bursts_left;
    logic [BEAT_W-1:0]   r_beat;
    logic                r_rd_req;
    logic                r_wr_ovf;
    logic [AW:0]         w_wr_used;
    logic [AW:0]         w_rd_used;
    logic [AW:0]         w_rd_free;
    logic                w_accept;
    logic                w_wr_push;
    logic                w_wr_pop;
    logic                w_rd_push;
    logic                w_rd_pop;
    logic                w_last_beat;
    logic                w_burst_end;

    assign w_accept    = cmd_valid & cmd_ready;
    assign w_wr_push   = wr_valid & wr_ready;
    assign w_wr_pop    = (r_state == S_WR_BURST) & ~avmm_m_waitrequest;
    assign w_rd_push   = (r_state == S_RD_DATA) & avmm_m_readdatavalid;
    assign w_rd_pop    = rd_ready & rd_valid;
    assign w_rd_free   = CNT_DEPTH - w_rd_used;
    assign w_last_beat = (r_beat == BEAT_W'(BURST_LEN - 1));
    assign w_burst_end = (w_wr_pop | w_rd_push) & w_last_beat;

    lpddr_burst_engine_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
        .i_clk  (avmm_m_clk),
        .i_rst  (avmm_m_rst),
        .i_push (w_wr_push),
        .i_data (wr_data),
        .i_pop  (w_wr_pop),
        .o_head (avmm_m_writedata),
        .o_used (w_wr_used)
    );

    lpddr_burst_engine_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rd_fifo (
        .i_clk  (avmm_m_clk),
        .i_rst  (avmm_m_rst),
        .i_push (w_rd_push),
        .i_data (avmm_m_readdata),
        .i_pop  (w_rd_pop),
        .o_head (rd_data),
        .o_used (w_rd_used)
    );

    always_ff @(posedge avmm_m_clk) begin
        if (avmm_m_rst) r_state <= S_IDLE;
        else            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (cmd_bursts == '0) w_next = S_DONE;
                    else if (cmd_write)   w_next = S_WR_WAIT;
                    else                  w_next = S_RD_ISSUE;
                end
            end
            S_WR_WAIT:  if (w_wr_used >= CNT_BURST) w_next = S_WR_BURST;
            S_WR_BURST: if (w_burst_end) w_next = (r_bursts_left == LEN_W'(1)) ? S_DONE : S_WR_WAIT;
            S_RD_ISSUE: if (r_rd_req && !avmm_m_waitrequest) w_next = S_RD_DATA;
            S_RD_DATA:  if (w_burst_end) w_next = (r_bursts_left == LEN_W'(1)) ? S_DONE : S_RD_ISSUE;
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready         = (r_state == S_IDLE) & ~avmm_m_rst;
        busy              = (r_state != S_IDLE);
        done              = (r_state == S_DONE);
        avmm_m_write      = (r_state == S_WR_BURST);
        avmm_m_read       = r_rd_req;
        avmm_m_address    = r_addr;
        avmm_m_burstcount = BURSTCOUNT_W'(BURST_LEN);
        wr_ready          = ~w_wr_used[AW];
        rd_valid          = (w_rd_used != '0);
        wr_overflow       = r_wr_ovf;
        o_dbg_state       = r_state;
    end

    always_ff @(posedge avmm_m_clk) begin
        if (avmm_m_rst) begin
            r_addr        <= '0;
            r_bursts_left <= '0;
            r_beat        <= '0;
            r_rd_req      <= 1'b0;
            r_wr_ovf      <= 1'b0;
        end else begin
            if (wr_valid && !wr_ready) r_wr_ovf <= 1'b1;
            if (w_accept) begin
                r_addr        <= cmd_address & ALIGN_MASK;
                r_bursts_left <= cmd_bursts;
                r_beat        <= '0;
            end else if (w_wr_pop || w_rd_push) begin
                r_beat <= r_beat + 1'b1;
                if (w_last_beat) begin
                    r_addr        <= r_addr + BSTEP;
                    r_bursts_left <= r_bursts_left - 1'b1;
                end
            end
            // Registered request: only issue once a whole burst is guaranteed to fit in the read FIFO.
            if (r_state == S_RD_ISSUE) begin
                if (!r_rd_req && (w_rd_free >= CNT_BURST)) r_rd_req <= 1'b1;
                else if (r_rd_req && !avmm_m_waitrequest)  r_rd_req <= 1'b0;
            end
        end
    end

`ifdef LPDDR_BURST_ENGINE_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_beat_cnt;
    logic        w_stall;

    assign w_stall   = (avmm_m_read | avmm_m_write) & avmm_m_waitrequest;
    assign stall_cnt = r_stall_cnt;
    assign beat_cnt  = r_beat_cnt;

    always_ff @(posedge avmm_m_clk) begin
        if (avmm_m_rst || w_accept) begin
            r_stall_cnt <= '0;
            r_beat_cnt  <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
            if ((w_wr_pop || w_rd_push) && (r_beat_cnt != '1)) r_beat_cnt <= r_beat_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_lpddr_burst_engine.sv
// Directed bench for lpddr_burst_engine: the bench plays the Avalon slave and keeps
// expected queues for write data, burst addresses and read-return data.

module tb_lpddr_burst_engine;
    localparam int DATA_W       = 32;
    localparam int ADDR_W       = 32;
    localparam int BURST_LEN    = 64;
    localparam int BURSTCOUNT_W = 7;
    localparam int LEN_W        = 16;
    localparam int FIFO_DEPTH   = 128;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    cmd_valid = 1'b0;
    logic                    cmd_ready;
    logic                    cmd_write = 1'b0;
    logic [ADDR_W-1:0]       cmd_address = '0;
    logic [LEN_W-1:0]        cmd_bursts = '0;
    logic [DATA_W-1:0]       wr_data = '0;
    logic                    wr_valid = 1'b0;
    logic                    wr_ready;
    logic [DATA_W-1:0]       rd_data;
    logic                    rd_valid;
    logic                    rd_ready = 1'b0;
    logic                    busy;
    logic                    done;
    logic                    wr_overflow;
    logic [ADDR_W-1:0]       avmm_m_address;
    logic [BURSTCOUNT_W-1:0] avmm_m_burstcount;
    logic                    avmm_m_write;
    logic [DATA_W-1:0]       avmm_m_writedata;
    logic                    avmm_m_read;
    logic                    avmm_m_waitrequest = 1'b1;
    logic [DATA_W-1:0]       avmm_m_readdata = '0;
    logic                    avmm_m_readdatavalid = 1'b0;
    logic [2:0]              dbg_state;
`ifdef LPDDR_BURST_ENGINE_PERF_EN
    logic [31:0]             stall_cnt;
    logic [31:0]             beat_cnt;
`endif

    logic [DATA_W-1:0] wexp_q[$];
    logic [DATA_W-1:0] rexp_q[$];
    logic [ADDR_W-1:0] aexp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    lpddr_burst_engine #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN),
        .BURSTCOUNT_W(BURSTCOUNT_W), .LEN_W(LEN_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .avmm_m_clk           (clk),
        .avmm_m_rst           (rst),
        .cmd_valid            (cmd_valid),
        .cmd_ready            (cmd_ready),
        .cmd_write            (cmd_write),
        .cmd_address          (cmd_address),
        .cmd_bursts           (cmd_bursts),
        .wr_data              (wr_data),
        .wr_valid             (wr_valid),
        .wr_ready             (wr_ready),
        .rd_data              (rd_data),
        .rd_valid             (rd_valid),
        .rd_ready             (rd_ready),
        .busy                 (busy),
        .done                 (done),
        .wr_overflow          (wr_overflow),
        .avmm_m_address       (avmm_m_address),
        .avmm_m_burstcount    (avmm_m_burstcount),
        .avmm_m_write         (avmm_m_write),
        .avmm_m_writedata     (avmm_m_writedata),
        .avmm_m_read          (avmm_m_read),
        .avmm_m_waitrequest   (avmm_m_waitrequest),
        .avmm_m_readdata      (avmm_m_readdata),
        .avmm_m_readdatavalid (avmm_m_readdatavalid),
`ifdef LPDDR_BURST_ENGINE_PERF_EN
        .stall_cnt            (stall_cnt),
        .beat_cnt             (beat_cnt),
`endif
        .o_dbg_state          (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_words(input int n, input bit ramp, input logic [DATA_W-1:0] base);
        for (int i = 0; i < n; i++) begin
            wr_data  = ramp ? base + DATA_W'(i) : DATA_W'($urandom);
            wr_valid = 1'b1;
            check("wr_ready", wr_ready, 1);
            wexp_q.push_back(wr_data);
            step();
        end
        wr_valid = 1'b0;
    endtask

    task automatic send_cmd(input bit wr, input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] n);
        int cyc = 0;
        while (cmd_ready !== 1'b1 && cyc < 200) begin
            step();
            cyc++;
        end
        check("cmd_ready", cmd_ready, 1);
        cmd_valid   = 1'b1;
        cmd_write   = wr;
        cmd_address = addr;
        cmd_bursts  = n;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic run_write(input int total, input bit toggle, input string tag);
        int  beats = 0;
        int  cyc = 0;
        bit  got_done = 1'b0;
        while (!got_done && cyc < 3000) begin
            avmm_m_waitrequest = toggle ? ((cyc % 2) == 1) : 1'b0;
            if (done === 1'b1) begin
                got_done = 1'b1;
            end else begin
                if ((beats % BURST_LEN) != 0) check({tag, "_no_gap"}, avmm_m_write, 1);
                if (avmm_m_write === 1'b1) begin
                    check({tag, "_addr"}, avmm_m_address, (aexp_q.size() > 0) ? aexp_q[0] : 32'hDEAD_BEEF);
                    if (!avmm_m_waitrequest) begin
                        check({tag, "_wdata"}, avmm_m_writedata,
                              (wexp_q.size() > 0) ? wexp_q.pop_front() : 32'hDEAD_BEEF);
                        beats++;
                        if ((beats % BURST_LEN) == 0 && aexp_q.size() > 0) void'(aexp_q.pop_front());
                    end
                end
                step();
                cyc++;
            end
        end
        avmm_m_waitrequest = 1'b1;
        check({tag, "_done_seen"}, got_done, 1);
        check({tag, "_beats"}, beats, total);
        check({tag, "_addr_left"}, aexp_q.size(), 0);
        step();
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_write_after"}, avmm_m_write, 0);
    endtask

    task automatic rd_serve(input logic [ADDR_W-1:0] addr, input bit first, input bit last);
        int cyc = 0;
        avmm_m_waitrequest = 1'b1;
        while (avmm_m_read !== 1'b1 && cyc < 300) begin
            step();
            cyc++;
        end
        check("rd_issue", avmm_m_read, 1);
        if (first) check("rd_latency", cyc, 1);
        check("rd_addr", avmm_m_address, addr);
        check("rd_burstcount", avmm_m_burstcount, BURST_LEN);
        step();
        check("rd_hold", avmm_m_read, 1);
        check("rd_hold_addr", avmm_m_address, addr);
        avmm_m_waitrequest = 1'b0;
        step();
        avmm_m_waitrequest = 1'b1;
        check("rd_drop", avmm_m_read, 0);
        for (int i = 0; i < BURST_LEN; i++) begin
            if ($urandom_range(0, 3) == 0) step();
            avmm_m_readdatavalid = 1'b1;
            avmm_m_readdata      = DATA_W'($urandom);
            rexp_q.push_back(avmm_m_readdata);
            step();
            avmm_m_readdatavalid = 1'b0;
        end
        check("rd_done", done, last);
        check("rd_single_outstanding", avmm_m_read, 0);
        check("rd_valid_after_burst", rd_valid, 1);
        if (last) begin
            step();
            check("rd_busy_after", busy, 0);
        end
    endtask

    task automatic pop_n(input int n);
        int i = 0;
        int cyc = 0;
        while (i < n && cyc < 2000) begin
            if (rd_valid === 1'b1) begin
                rd_ready = 1'b1;
                check("rd_data", rd_data, (rexp_q.size() > 0) ? rexp_q.pop_front() : 32'hDEAD_BEEF);
                i++;
            end else begin
                rd_ready = 1'b0;
            end
            step();
            cyc++;
        end
        rd_ready = 1'b0;
        check("rd_pop_count", i, n);
    endtask

    initial begin
        int  beats;
        int  cyc;
        bit  seen;

        // Reset state
        step();
        check("rst_cmd_ready", cmd_ready, 0);
        step();
        rst = 1'b0;
        step();
        check("rst_cmd_ready_idle", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overflow", wr_overflow, 0);
        check("rst_write", avmm_m_write, 0);
        check("rst_read", avmm_m_read, 0);
        check("rst_address", avmm_m_address, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_wr_ready", wr_ready, 1);

        // Two write bursts from a pre-filled FIFO, plus a sticky overflow
        push_words(128, 1'b1, 32'd0);
        check("w1_full", wr_ready, 0);
        wr_valid = 1'b1;
        wr_data  = 32'hBAD0_BAD0;
        step();
        wr_valid = 1'b0;
        check("w1_overflow", wr_overflow, 1);
        aexp_q.push_back(32'h0000_1000);
        aexp_q.push_back(32'h0000_1100);
        send_cmd(1'b1, 32'h0000_1000, 16'd2);
        run_write(128, 1'b0, "w1");
        check("w1_overflow_sticky", wr_overflow, 1);

        // Write burst with waitrequest toggling; unaligned address must be truncated
        push_words(64, 1'b0, 32'd0);
        aexp_q.push_back(32'h0000_3000);
        send_cmd(1'b1, 32'h0000_30A4, 16'd1);
        run_write(64, 1'b1, "w2");

        // Zero-burst commands complete without bus activity
        send_cmd(1'b1, 32'h0000_5000, 16'd0);
        check("z_wr_done", done, 1);
        check("z_wr_write", avmm_m_write, 0);
        check("z_wr_read", avmm_m_read, 0);
        step();
        check("z_wr_done_clear", done, 0);
        check("z_wr_busy", busy, 0);
        send_cmd(1'b0, 32'h0000_5000, 16'd0);
        check("z_rd_done", done, 1);
        check("z_rd_read", avmm_m_read, 0);
        step();
        check("z_rd_busy", busy, 0);
        check("z_rd_read_after", avmm_m_read, 0);

        // Three read bursts with the consumer stalled: the third waits for FIFO space
        send_cmd(1'b0, 32'h0000_2000, 16'd3);
        rd_serve(32'h0000_2000, 1'b1, 1'b0);
        rd_serve(32'h0000_2100, 1'b0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            seen |= (avmm_m_read === 1'b1);
            step();
        end
        check("rd_holdoff", seen, 0);
        check("rd_holdoff_busy", busy, 1);
        pop_n(64);
        rd_serve(32'h0000_2200, 1'b0, 1'b1);
        pop_n(128);
        check("rd_all_delivered", rexp_q.size(), 0);
        check("rd_valid_empty", rd_valid, 0);

        // Reset at beat 30 of a write burst
        push_words(64, 1'b0, 32'd0);
        aexp_q.push_back(32'h0000_4000);
        send_cmd(1'b1, 32'h0000_4000, 16'd1);
        beats = 0;
        cyc   = 0;
        avmm_m_waitrequest = 1'b0;
        while (beats < 30 && cyc < 300) begin
            if (avmm_m_write === 1'b1) begin
                check("r_wdata", avmm_m_writedata, (wexp_q.size() > 0) ? wexp_q.pop_front() : 32'hDEAD_BEEF);
                beats++;
            end
            if (beats < 30) step();
            cyc++;
        end
        check("r_beats_before_reset", beats, 30);
        rst = 1'b1;
        step();
        avmm_m_waitrequest = 1'b1;
        check("r_write_drop", avmm_m_write, 0);
        check("r_busy", busy, 0);
        check("r_wr_ready", wr_ready, 1);
        check("r_done", done, 0);
        check("r_cmd_ready_in_reset", cmd_ready, 0);
        check("r_overflow_clear", wr_overflow, 0);
        check("r_address", avmm_m_address, 0);
        wexp_q.delete();
        aexp_q.delete();
        rst = 1'b0;
        step();
        push_words(64, 1'b1, 32'h0000_A000);
        aexp_q.push_back(32'h0000_4000);
        send_cmd(1'b1, 32'h0000_4000, 16'd1);
        run_write(64, 1'b0, "w5");

        // Address wrap across the top of the space
        push_words(128, 1'b1, 32'h0000_C000);
        aexp_q.push_back(32'hFFFF_FF00);
        aexp_q.push_back(32'h0000_0000);
        send_cmd(1'b1, 32'hFFFF_FF2C, 16'd2);
        run_write(128, 1'b0, "w6");
        check("w6_fifo_drained", wexp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
